// File: rtl/snn_axi_pkg.sv
// Shared constants for the SNN coprocessor AXI4-Lite register interface.
//   RESP_OKAY          : AXI response code returned for every transaction.
//   ADDR_DIGIT         : word index of the read-only inferred-digit register.
//   ADDR_CTRL          : word index of the control register (first index past the image).
//   CTRL_NEW_IMAGE_BIT : bit of the control register that starts inference.
package snn_axi_pkg;

  localparam int unsigned PKG_IMAGE_SIZE     = 256;
  localparam logic [1:0]  RESP_OKAY          = 2'b00;
  localparam int unsigned ADDR_DIGIT         = 0;
  localparam int unsigned ADDR_CTRL          = PKG_IMAGE_SIZE;
  localparam int unsigned CTRL_NEW_IMAGE_BIT = 0;

endpackage

// File: rtl/s_axi4l_image_interface.sv
// AXI4-Lite slave linking the host CPU to the SNN coprocessor.
// The host writes one pixel per transaction into image_data, toggles NEW_IMAGE
// through the control register and reads back the inferred digit.
// Ports:
//   ACLK / ARESETN            : clock, asynchronous active-low reset
//   AW*/W*/B*                 : AXI4-Lite write channels (addresses are word indices)
//   AR*/R*                    : AXI4-Lite read channels
//   INFERED_DIGIT             : digit result from the SNN core
//   IMAGE                     : continuous view of the pixel register array
//   NEW_IMAGE                 : control bit that starts inference (level register)
module s_axi4l_image_interface
  import snn_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned IMAGE_SIZE      = 256,
  parameter int unsigned IMAGE_SIZE_BITS = 8,
  parameter int unsigned PIXEL_MAX_VALUE = 255,
  parameter int unsigned PIXEL_BITS      = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]                AWPROT,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]                ARPROT,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  input  logic [7:0]                INFERED_DIGIT,
  output logic [PIXEL_BITS-1:0]     IMAGE [IMAGE_SIZE],
  output logic                      NEW_IMAGE
);

  // ---------------- write channel ----------------
  logic awready_q, awready_d;
  logic wready_q,  wready_d;
  logic bvalid_q,  bvalid_d;
  logic wr_en;

  // The ready pulse is raised one cycle after both valids are seen; the
  // transfer completes on the edge that ends the ready cycle.
  assign wr_en = awready_q & AWVALID & wready_q & WVALID;

  always_comb begin
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    if (AWVALID && WVALID && !bvalid_q && !awready_q) begin
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end
    if (wr_en)
      bvalid_d = 1'b1;
    else if (bvalid_q && BREADY)
      bvalid_d = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // ---------------- read channel ----------------
  logic                      arready_q, arready_d;
  logic                      rvalid_q,  rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                      new_image_q, new_image_d;
  logic                      rd_en;

  assign rd_en = arready_q & ARVALID & ~rvalid_q;

  always_comb begin
    arready_d = ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_en) begin
      rvalid_d = 1'b1;
      if (ARADDR == AXI_ADDR_WIDTH'(ADDR_DIGIT))
        rdata_d = AXI_DATA_WIDTH'(INFERED_DIGIT);
      else if (ARADDR == AXI_ADDR_WIDTH'(ADDR_CTRL))
        rdata_d = AXI_DATA_WIDTH'(new_image_q) << CTRL_NEW_IMAGE_BIT;
      else
        rdata_d = '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  // ---------------- register file ----------------
  logic [PIXEL_BITS-1:0] image_q [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0] image_d [IMAGE_SIZE];

  always_comb begin
    image_d     = image_q;
    new_image_d = new_image_q;
    if (wr_en && WSTRB[0]) begin
      if (AWADDR < AXI_ADDR_WIDTH'(IMAGE_SIZE))
        image_d[AWADDR[IMAGE_SIZE_BITS-1:0]] = WDATA[PIXEL_BITS-1:0];
      else if (AWADDR == AXI_ADDR_WIDTH'(ADDR_CTRL))
        new_image_d = WDATA[CTRL_NEW_IMAGE_BIT];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < IMAGE_SIZE; i++)
        image_q[i] <= '0;
      new_image_q <= 1'b0;
    end else begin
      image_q     <= image_d;
      new_image_q <= new_image_d;
    end
  end

  // ---------------- outputs ----------------
  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = RESP_OKAY;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = RESP_OKAY;
  assign IMAGE     = image_q;
  assign NEW_IMAGE = new_image_q;

  // Protection bits, upper strobes and upper data bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, WSTRB[3:1], WDATA[AXI_DATA_WIDTH-1:PIXEL_BITS],
                       PIXEL_MAX_VALUE[0]};

endmodule

// File: tb/tb_s_axi4l_image_interface.sv
// Directed self-checking bench for s_axi4l_image_interface.
module tb_s_axi4l_image_interface;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  INFERED_DIGIT;
  logic [7:0]  IMAGE [256];
  logic        NEW_IMAGE;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_img [256];

  always #5 ACLK = ~ACLK;

  s_axi4l_image_interface #(
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (32),
    .IMAGE_SIZE     (256),
    .IMAGE_SIZE_BITS(8),
    .PIXEL_MAX_VALUE(255),
    .PIXEL_BITS     (8)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .AWADDR       (AWADDR),
    .AWPROT       (AWPROT),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .ARADDR       (ARADDR),
    .ARPROT       (ARPROT),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .INFERED_DIGIT(INFERED_DIGIT),
    .IMAGE        (IMAGE),
    .NEW_IMAGE    (NEW_IMAGE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Wait (bounded) until AWREADY is seen high; both readies must rise together.
  task automatic wait_awready();
    int unsigned n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("awready_seen", {31'b0, AWREADY}, 32'd1);
    chk("wready_with_awready", {31'b0, WREADY}, 32'd1);
  endtask

  // Complete a write: drop valids after the ready cycle and check the B response.
  task automatic finish_write();
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("bvalid_after_accept", {31'b0, BVALID}, 32'd1);
    chk("bresp_okay", {30'b0, BRESP}, 32'd0);
    chk("awready_one_cycle", {31'b0, AWREADY}, 32'd0);
    BREADY = 1'b1;
    tick();
    chk("bvalid_dropped", {31'b0, BVALID}, 32'd0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    wait_awready();
    finish_write();
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    int unsigned n = 0;
    ARADDR  = addr;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    while (ARREADY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_arready"}, {31'b0, ARREADY}, 32'd1);
    tick();
    ARVALID = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, RVALID}, 32'd1);
    chk({tag, "_rdata"}, RDATA, exp);
    chk({tag, "_rresp"}, {30'b0, RRESP}, 32'd0);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk({tag, "_rvalid_drop"}, {31'b0, RVALID}, 32'd0);
  endtask

  initial begin
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    INFERED_DIGIT = '0;

    // ---- reset ----
    #100;
    chk("rst_awready", {31'b0, AWREADY}, 32'd0);
    chk("rst_wready", {31'b0, WREADY}, 32'd0);
    chk("rst_bvalid", {31'b0, BVALID}, 32'd0);
    chk("rst_bresp", {30'b0, BRESP}, 32'd0);
    chk("rst_arready", {31'b0, ARREADY}, 32'd0);
    chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
    chk("rst_rresp", {30'b0, RRESP}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_new_image", {31'b0, NEW_IMAGE}, 32'd0);
    for (int i = 0; i < 256; i++) chk("rst_image", {24'b0, IMAGE[i]}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();

    // ---- AWVALID alone / WVALID alone never get ready ----
    AWVALID = 1'b1; AWADDR = 32'd1; WDATA = 32'h77; WSTRB = 4'h1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("aw_alone_no_ready", {31'b0, AWREADY}, 32'd0);
    end
    AWVALID = 1'b0; WVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w_alone_no_wready", {31'b0, WREADY}, 32'd0);
    end
    WVALID = 1'b0;
    tick();
    chk("alone_no_write", {24'b0, IMAGE[1]}, 32'd0);

    // ---- full image write ----
    for (int i = 0; i < 256; i++) begin
      exp_img[i] = 8'((i * 7 + 1) % 256);
      if (i == 56) exp_img[i] = 8'd3;
      if (i == 74) exp_img[i] = 8'd244;
      axi_write(32'(i), {24'hABCDEF, exp_img[i]}, 4'h1);
    end
    for (int i = 0; i < 256; i++) chk("image_pixel", {24'b0, IMAGE[i]}, {24'b0, exp_img[i]});
    chk("image_56", {24'b0, IMAGE[56]}, 32'd3);
    chk("image_74", {24'b0, IMAGE[74]}, 32'd244);

    // ---- NEW_IMAGE control ----
    axi_write(32'd256, 32'h1, 4'h1);
    chk("new_image_set", {31'b0, NEW_IMAGE}, 32'd1);
    axi_read(32'd256, 32'd1, "rd_ctrl1");
    axi_write(32'd256, 32'h0, 4'h1);
    chk("new_image_clr", {31'b0, NEW_IMAGE}, 32'd0);
    axi_read(32'd256, 32'd0, "rd_ctrl0");

    // ---- out-of-map write is discarded but acknowledged ----
    axi_write(32'd300, 32'h1, 4'h1);
    chk("oob_new_image", {31'b0, NEW_IMAGE}, 32'd0);
    chk("oob_image_44", {24'b0, IMAGE[44]}, {24'b0, exp_img[44]});

    // ---- strobe 0 leaves registers unchanged ----
    axi_write(32'd3, 32'h5A, 4'h0);
    chk("wstrb0_image3", {24'b0, IMAGE[3]}, {24'b0, exp_img[3]});
    axi_write(32'd256, 32'h1, 4'h0);
    chk("wstrb0_ctrl", {31'b0, NEW_IMAGE}, 32'd0);

    // ---- digit read with RREADY held low ----
    INFERED_DIGIT = 8'd5;
    ARADDR = 32'd0; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    chk("digit_arready", {31'b0, ARREADY}, 32'd1);
    tick();
    ARVALID = 1'b0;
    INFERED_DIGIT = 8'd9;
    for (int i = 0; i < 3; i++) begin
      chk("digit_rvalid_hold", {31'b0, RVALID}, 32'd1);
      chk("digit_rdata_hold", RDATA, 32'h5);
      chk("digit_rresp", {30'b0, RRESP}, 32'd0);
      tick();
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("digit_rvalid_drop", {31'b0, RVALID}, 32'd0);
    axi_read(32'd0, 32'h9, "rd_digit9");
    axi_read(32'd7, 32'h0, "rd_unmapped");

    // ---- B backpressure blocks the next write ----
    AWADDR = 32'd10; WDATA = 32'h11; WSTRB = 4'h1; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    wait_awready();
    tick();
    AWADDR = 32'd11; WDATA = 32'h22;
    chk("bp_first_bvalid", {31'b0, BVALID}, 32'd1);
    exp_img[10] = 8'h11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_no_awready", {31'b0, AWREADY}, 32'd0);
      chk("bp_no_wready", {31'b0, WREADY}, 32'd0);
      chk("bp_bvalid_hold", {31'b0, BVALID}, 32'd1);
    end
    chk("bp_image11_untouched", {24'b0, IMAGE[11]}, {24'b0, exp_img[11]});
    BREADY = 1'b1;
    tick();
    chk("bp_bvalid_released", {31'b0, BVALID}, 32'd0);
    BREADY = 1'b0;
    wait_awready();
    finish_write();
    exp_img[11] = 8'h22;
    chk("bp_image10", {24'b0, IMAGE[10]}, {24'b0, exp_img[10]});
    chk("bp_image11", {24'b0, IMAGE[11]}, {24'b0, exp_img[11]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
